// File: rtl/laser_bus_pkg.sv
// Shared Z80 bus access codes and bridge FSM encodings for the Laser500 memory/IO arbiter path.
package laser_bus_pkg;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_MEMRD,
    ACC_MEMWR,
    ACC_IORD,
    ACC_IOWR,
    ACC_INTA,
    ACC_RFSH
  } acc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WR_POST
  } state_t;

  localparam int TMO_W = 10;

  // Only real memory/IO transfers reach the arbiter; INTA and refresh are handled locally.
  function automatic logic acc_is_req(input acc_t a);
    return (a == ACC_MEMRD) || (a == ACC_MEMWR) || (a == ACC_IORD) || (a == ACC_IOWR);
  endfunction

  function automatic logic acc_is_wr(input acc_t a);
    return (a == ACC_MEMWR) || (a == ACC_IOWR);
  endfunction

endpackage

// File: rtl/z80_bus_decode.sv
// Combinational Z80 strobe decode into a single access type; no state, no latency, no backpressure.
module z80_bus_decode
  import laser_bus_pkg::*;
(
  input  logic i_mreq_n,
  input  logic i_iorq_n,
  input  logic i_rd_n,
  input  logic i_wr_n,
  input  logic i_m1_n,
  input  logic i_rfsh_n,
  output acc_t o_acc,
  output logic o_idle_bus
);

  always_comb begin
    o_acc = ACC_NONE;
    if (!i_mreq_n) begin
      if (!i_rfsh_n)   o_acc = ACC_RFSH;
      else if (!i_rd_n) o_acc = ACC_MEMRD;
      else if (!i_wr_n) o_acc = ACC_MEMWR;
    end else if (!i_iorq_n) begin
      // M1 with IORQ is interrupt acknowledge, which takes precedence over any rd/wr.
      if (!i_m1_n)      o_acc = ACC_INTA;
      else if (!i_rd_n) o_acc = ACC_IORD;
      else if (!i_wr_n) o_acc = ACC_IOWR;
    end
  end

  assign o_idle_bus = i_mreq_n & i_iorq_n & i_rd_n & i_wr_n;

endmodule

// File: rtl/z80_bus_bridge.sv
// Z80 bus cycle -> single req/ack port; reads stall the CPU via cpu_wait_n until ack (>= 2 clk),
// writes are posted through a one-entry buffer; hung requests abort after TIMEOUT cycles.
module z80_bus_bridge
  import laser_bus_pkg::*;
#(
  parameter int          TIMEOUT    = 1023,
  parameter logic [7:0]  TIMEOUT_RD = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_rfsh_n,
  output logic        cpu_wait_n,
  input  logic [7:0]  int_vector,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        timeout_err
);

  acc_t             w_acc;
  logic             w_idle_bus;
  logic             w_access;
  logic             w_accept;
  logic             w_tmo_hit;

  state_t           r_state;
  logic             r_cycle_done;
  logic             r_mem_req;
  logic             r_mem_we;
  logic             r_mem_io;
  logic [15:0]      r_mem_addr;
  logic [7:0]       r_mem_wdata;
  logic [7:0]       r_rd_data;
  logic             r_timeout_err;
  logic [TMO_W-1:0] r_tmo_cnt;

  z80_bus_decode u_decode (
    .i_mreq_n   (cpu_mreq_n),
    .i_iorq_n   (cpu_iorq_n),
    .i_rd_n     (cpu_rd_n),
    .i_wr_n     (cpu_wr_n),
    .i_m1_n     (cpu_m1_n),
    .i_rfsh_n   (cpu_rfsh_n),
    .o_acc      (w_acc),
    .o_idle_bus (w_idle_bus)
  );

  assign w_access  = acc_is_req(w_acc);
  assign w_accept  = w_access && !r_cycle_done && (r_state == ST_IDLE);
  // Abort on the cycle the counter would reach TIMEOUT, so mem_req is high for exactly TIMEOUT cycles.
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

  assign cpu_wait_n  = ~(w_access & ~r_cycle_done);
  assign cpu_di      = (w_acc == ACC_INTA) ? int_vector : r_rd_data;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_io      = r_mem_io;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cycle_done  <= 1'b1;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_io      <= 1'b0;
      r_mem_addr    <= 16'h0000;
      r_mem_wdata   <= 8'h00;
      r_rd_data     <= 8'hFF;
      r_timeout_err <= 1'b0;
      r_tmo_cnt     <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      if (w_idle_bus) r_cycle_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= cpu_a;
            r_mem_io   <= (w_acc == ACC_IORD) || (w_acc == ACC_IOWR);
            r_tmo_cnt  <= '0;
            if (acc_is_wr(w_acc)) begin
              // Posted write: the CPU is released on the accept edge.
              r_mem_we     <= 1'b1;
              r_mem_wdata  <= cpu_dout;
              r_cycle_done <= 1'b1;
              r_state      <= ST_WR_POST;
            end else begin
              r_mem_we <= 1'b0;
              r_state  <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          if (mem_ack) begin
            r_rd_data    <= mem_rdata;
            r_cycle_done <= 1'b1;
            r_mem_req    <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (w_tmo_hit) begin
            r_rd_data     <= TIMEOUT_RD;
            r_cycle_done  <= 1'b1;
            r_mem_req     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ST_WR_POST: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_tmo_hit) begin
            r_mem_req     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed bench for z80_bus_bridge: strobes driven on negedge, outputs sampled 1ns after posedge.
module tb_z80_bus_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_di;
  logic        cpu_mreq_n = 1'b1, cpu_iorq_n = 1'b1, cpu_rd_n = 1'b1;
  logic        cpu_wr_n = 1'b1, cpu_m1_n = 1'b1, cpu_rfsh_n = 1'b1;
  logic        cpu_wait_n;
  logic [7:0]  int_vector = 8'h00;
  logic        mem_req, mem_we, mem_io;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  int req_cnt = 0;
  int tmo_seen = 0;
  logic prev_req = 1'b0;

  // {mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n}
  localparam logic [5:0] S_IDLE  = 6'b111111;
  localparam logic [5:0] S_MEMRD = 6'b010111;
  localparam logic [5:0] S_MEMWR = 6'b011011;
  localparam logic [5:0] S_IORD  = 6'b100111;
  localparam logic [5:0] S_INTA  = 6'b101101;
  localparam logic [5:0] S_RFSH  = 6'b011110;

  z80_bus_bridge dut (
    .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_di(cpu_di),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_m1_n(cpu_m1_n), .cpu_rfsh_n(cpu_rfsh_n), .cpu_wait_n(cpu_wait_n), .int_vector(int_vector),
    .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    prev_req <= mem_req;
    if (mem_req && !prev_req) req_cnt <= req_cnt + 1;
    if (timeout_err) tmo_seen <= tmo_seen + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic [5:0] s);
    @(negedge clk);
    cpu_a = a;
    cpu_dout = d;
    {cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n} = s;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests++; if ({mem_req, mem_we, mem_io} !== 3'b000) begin fails++; $display("FAIL rst_ctl got %b exp 000", {mem_req, mem_we, mem_io}); end
    tests++; if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin fails++; $display("FAIL rst_bus got %h/%h exp 0000/00", mem_addr, mem_wdata); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_tmo got %b exp 0", timeout_err); end
    tests++; if (cpu_di !== 8'hFF) begin fails++; $display("FAIL rst_di got %h exp FF", cpu_di); end
    tests++; if (cpu_wait_n !== 1'b1) begin fails++; $display("FAIL rst_wait got %b exp 1", cpu_wait_n); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_memrd();
    int base;
    base = req_cnt;
    bus(16'h8000, 8'h00, S_MEMRD);
    tests++; if (cpu_wait_n !== 1'b0) begin fails++; $display("FAIL rd_wait_pre got %b exp 0", cpu_wait_n); end
    tick();
    tests++; if ({mem_req, mem_we, mem_io} !== 3'b100 || mem_addr !== 16'h8000) begin fails++; $display("FAIL rd_req got %b %h exp 100 8000", {mem_req, mem_we, mem_io}, mem_addr); end
    tick();
    tick();
    tests++; if (cpu_wait_n !== 1'b0 || mem_req !== 1'b1) begin fails++; $display("FAIL rd_hold got wait=%b req=%b exp 0 1", cpu_wait_n, mem_req); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    tests++; if (cpu_wait_n !== 1'b1 || cpu_di !== 8'h5A || mem_req !== 1'b0) begin fails++; $display("FAIL rd_done got wait=%b di=%h req=%b exp 1 5A 0", cpu_wait_n, cpu_di, mem_req); end
    repeat (2) tick();
    bus(16'h0000, 8'h00, S_IDLE);
    repeat (2) tick();
    tests++; if (req_cnt - base !== 1 || cpu_di !== 8'h5A) begin fails++; $display("FAIL rd_single got reqs=%0d di=%h exp 1 5A", req_cnt - base, cpu_di); end
  endtask

  task automatic test_memwr();
    bus(16'hC123, 8'h77, S_MEMWR);
    tick();
    for (int i = 1; i < 10; i++) begin
      if (i == 3) bus(16'h0000, 8'h00, S_IDLE);
      if (i != 3) tick(); else tick();
      tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_wait_n} !== {1'b1, 1'b1, 16'hC123, 8'h77, 1'b1}) begin
        fails++; $display("FAIL wr_post[%0d] got req=%b we=%b a=%h d=%h wait=%b exp 1 1 C123 77 1", i, mem_req, mem_we, mem_addr, mem_wdata, cpu_wait_n);
      end
    end
    @(negedge clk);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL wr_ack got req=%b exp 0", mem_req); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus(16'h1000, 8'h33, S_MEMWR);
    tick();
    bus(16'h0000, 8'h00, S_IDLE);
    tick();
    bus(16'h00FE, 8'h00, S_IORD);
    tick();
    tests++; if (cpu_wait_n !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 16'h1000) begin fails++; $display("FAIL b2b_stall got wait=%b we=%b a=%h exp 0 1 1000", cpu_wait_n, mem_we, mem_addr); end
    repeat (3) tick();
    @(negedge clk);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if (mem_req !== 1'b0 || cpu_wait_n !== 1'b0) begin fails++; $display("FAIL b2b_wack got req=%b wait=%b exp 0 0", mem_req, cpu_wait_n); end
    tick();
    tests++; if ({mem_req, mem_we, mem_io} !== 3'b101 || mem_addr !== 16'h00FE || cpu_wait_n !== 1'b0) begin fails++; $display("FAIL b2b_io got %b %h wait=%b exp 101 00FE 0", {mem_req, mem_we, mem_io}, mem_addr, cpu_wait_n); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    tests++; if (cpu_wait_n !== 1'b1 || cpu_di !== 8'h3C || mem_req !== 1'b0) begin fails++; $display("FAIL b2b_iord got wait=%b di=%h req=%b exp 1 3C 0", cpu_wait_n, cpu_di, mem_req); end
    bus(16'h0000, 8'h00, S_IDLE);
    tick();
  endtask

  task automatic test_inta_rfsh();
    int base;
    base = req_cnt;
    int_vector = 8'hFF;
    bus(16'h0038, 8'h00, S_INTA);
    repeat (2) tick();
    tests++; if (cpu_di !== 8'hFF || cpu_wait_n !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL inta_ff got di=%h wait=%b req=%b exp FF 1 0", cpu_di, cpu_wait_n, mem_req); end
    int_vector = 8'hC7;
    #1;
    tests++; if (cpu_di !== 8'hC7) begin fails++; $display("FAIL inta_c7 got %h exp C7", cpu_di); end
    bus(16'h0000, 8'h00, S_IDLE);
    tick();
    bus(16'h0042, 8'h00, S_RFSH);
    repeat (2) tick();
    tests++; if (cpu_di !== 8'h3C || cpu_wait_n !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL rfsh got di=%h wait=%b req=%b exp 3C 1 0", cpu_di, cpu_wait_n, mem_req); end
    bus(16'h0000, 8'h00, S_IDLE);
    tick();
    tests++; if (req_cnt - base !== 0) begin fails++; $display("FAIL inta_rfsh_reqs got %0d exp 0", req_cnt - base); end
  endtask

  task automatic test_timeout();
    int n;
    int base;
    base = tmo_seen;
    bus(16'h2000, 8'h00, S_MEMRD);
    tick();
    tests++; if (mem_req !== 1'b1 || cpu_wait_n !== 1'b0) begin fails++; $display("FAIL tmo_start got req=%b wait=%b exp 1 0", mem_req, cpu_wait_n); end
    n = 0;
    while (mem_req === 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    tests++; if (n !== 1023) begin fails++; $display("FAIL tmo_len got %0d exp 1023", n); end
    tests++; if (timeout_err !== 1'b1 || cpu_di !== 8'hFF || cpu_wait_n !== 1'b1) begin fails++; $display("FAIL tmo_abort got err=%b di=%h wait=%b exp 1 FF 1", timeout_err, cpu_di, cpu_wait_n); end
    tick();
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL tmo_pulse got %b exp 0", timeout_err); end
    bus(16'h0000, 8'h00, S_IDLE);
    repeat (2) tick();
    tests++; if (tmo_seen - base !== 1) begin fails++; $display("FAIL tmo_count got %0d exp 1", tmo_seen - base); end
  endtask

  task automatic test_reset_midread();
    int base;
    base = req_cnt;
    bus(16'h4000, 8'h00, S_MEMRD);
    tick();
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL mrst_req got %b exp 1", mem_req); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    tests++; if (mem_req !== 1'b0 || cpu_wait_n !== 1'b1) begin fails++; $display("FAIL mrst_drop got req=%b wait=%b exp 0 1", mem_req, cpu_wait_n); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick();
    tests++; if (mem_req !== 1'b0 || cpu_wait_n !== 1'b1 || req_cnt - base !== 1) begin fails++; $display("FAIL mrst_noreissue got req=%b wait=%b reqs=%0d exp 0 1 1", mem_req, cpu_wait_n, req_cnt - base); end
    bus(16'h0000, 8'h00, S_IDLE);
    tick();
  endtask

  initial begin
    test_reset();
    test_memrd();
    test_memwr();
    test_back_to_back();
    test_inta_rfsh();
    test_timeout();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
